// File: rtl/pa_isa_pkg.sv
// Shared ISA definitions: opcode constants, function types and the
// records exchanged between pre-decode and the hazard scoreboard.
package pa_isa_pkg;

    localparam int DEFAULT_LATENCY = 3;

    // Non-branch opcode space
    localparam logic [6:0] OP_NOP        = 7'd0;
    localparam logic [6:0] OP_ADD        = 7'd1;
    localparam logic [6:0] OP_SUB        = 7'd2;
    localparam logic [6:0] OP_MUL        = 7'd3;
    localparam logic [6:0] OP_LDI        = 7'd10;
    localparam logic [6:0] OP_LD         = 7'd11;
    localparam logic [6:0] OP_ST         = 7'd12;
    localparam logic [6:0] OP_FRAME_INC  = 7'd20;
    localparam logic [6:0] OP_FRAME_DEC  = 7'd21;
    localparam logic [6:0] OP_FRAME_PUSH = 7'd22;
    localparam logic [6:0] OP_FRAME_POP  = 7'd23;
    localparam logic [6:0] OP_FRAME_JMP  = 7'd24;

    // Branch opcode space: 1-4 compare two registers, 5-8 test one
    localparam logic [6:0] BR_EQ  = 7'd1;
    localparam logic [6:0] BR_NE  = 7'd2;
    localparam logic [6:0] BR_LT  = 7'd3;
    localparam logic [6:0] BR_GE  = 7'd4;
    localparam logic [6:0] BR_Z   = 7'd5;
    localparam logic [6:0] BR_NZ  = 7'd6;
    localparam logic [6:0] BR_NEG = 7'd7;
    localparam logic [6:0] BR_POS = 7'd8;

    typedef enum logic [1:0] {
        FUNC_ARITH  = 2'd0,
        FUNC_MEM    = 2'd1,
        FUNC_BRANCH = 2'd2,
        FUNC_FRAME  = 2'd3
    } func_type_e;

    typedef struct packed {
        logic p_read;
        logic p_write;
        logic s_read;
        logic is_frame;
    } op_usage_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/op_usage_predecode.sv
// Combinational register-usage pre-decode; shared with the Decode stage.
module op_usage_predecode
    import pa_isa_pkg::*;
(
    input  logic       is_branch,
    input  logic       instruction_format,
    input  logic [6:0] opcode,
    output op_usage_t  usage
);

    always_comb begin
        usage = '0;
        if (is_branch) begin
            if (opcode >= BR_EQ && opcode <= BR_POS) begin
                usage.p_read = 1'b1;
                usage.s_read = ~instruction_format & (opcode <= BR_GE);
            end
        end else begin
            case (opcode)
                OP_ADD, OP_SUB, OP_MUL: begin
                    usage.p_read  = 1'b1;
                    usage.p_write = 1'b1;
                    usage.s_read  = ~instruction_format;
                end
                OP_LDI, OP_LD: begin
                    usage.p_write = 1'b1;
                    usage.s_read  = ~instruction_format;
                end
                OP_ST: begin
                    usage.p_read = 1'b1;
                    usage.s_read = ~instruction_format;
                end
                OP_FRAME_INC, OP_FRAME_DEC, OP_FRAME_PUSH, OP_FRAME_POP, OP_FRAME_JMP: begin
                    usage.is_frame = 1'b1;
                    usage.s_read   = ~instruction_format & (opcode == OP_FRAME_JMP);
                end
                default: usage = '0;
            endcase
        end
    end

endmodule

// File: rtl/dependency_check.sv
// Read-after-write hazard unit: shift-register scoreboard of recent writes
// and the stall line that holds fetch and Decode.
module dependency_check
    import pa_isa_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
)
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        flushBack_i,
    input  logic        isBranch_i,
    input  logic        instructionFormat_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  primOperand_i,
    input  logic [15:0] secOperand_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [15:0] stallCount_o
);

    localparam int DEPTH = LATENCY - 1;

    op_usage_t   usage;
    sb_entry_t   sb_q [DEPTH];
    sb_entry_t   ins_entry;
    logic        hazard;
    logic        busy_q;
    logic        busy_next;
    logic [15:0] stall_cnt_q;
    logic        unused_sec_bits;

    assign unused_sec_bits = ^secOperand_i[15:5];

    op_usage_predecode u_predecode (
        .is_branch          (isBranch_i),
        .instruction_format (instructionFormat_i),
        .opcode             (opcode_i),
        .usage              (usage)
    );

    always_comb begin
        hazard = usage.is_frame & busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_q[i].valid) begin
                if (usage.p_read && sb_q[i].dest == primOperand_i)
                    hazard = 1'b1;
                if (usage.s_read && sb_q[i].dest == secOperand_i[4:0])
                    hazard = 1'b1;
            end
        end
    end

    assign stall_o = enable_i & ~flushBack_i & ~reset_i & hazard;

    // busy reflects the entries that will be held after the edge, so the
    // oldest entry (about to be discarded) is left out of the OR.
    always_comb begin
        ins_entry.valid = enable_i & ~stall_o & ~flushBack_i & usage.p_write;
        ins_entry.dest  = primOperand_i;
        busy_next       = ins_entry.valid;
        for (int i = 0; i < DEPTH - 1; i++)
            busy_next = busy_next | sb_q[i].valid;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                sb_q[i] <= '0;
            busy_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            sb_q[0] <= ins_entry;
            for (int i = 1; i < DEPTH; i++)
                sb_q[i] <= sb_q[i-1];
            busy_q <= busy_next;
            if (stall_o && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign busy_o       = busy_q;
    assign stallCount_o = stall_cnt_q;

endmodule

// File: tb/tb_dependency_check.sv
// Directed-vector bench for dependency_check: expectations are queued when
// stimulus is applied and popped by a monitor on the falling edge.
module tb_dependency_check;
    import pa_isa_pkg::*;

    typedef struct packed {
        logic         stall;
        logic         busy;
        logic [15:0]  cnt;
        logic [127:0] name;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst = 1'b1, en = 1'b0, fl = 1'b0, br = 1'b0, fmt = 1'b0;
    logic [6:0]  op = '0;
    logic [4:0]  prim = '0;
    logic [15:0] sec = '0;
    logic        stall, busy;
    logic [15:0] cnt;

    logic        rst8 = 1'b1;
    logic        stall8, busy8;
    logic [15:0] cnt8;

    exp_t        q[$];
    exp_t        q8[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] model_cnt = 16'd0;

    always #5 clock = ~clock;

    dependency_check #(.LATENCY(3)) dut (
        .clock_i(clock), .reset_i(rst), .enable_i(en), .flushBack_i(fl),
        .isBranch_i(br), .instructionFormat_i(fmt), .opcode_i(op),
        .primOperand_i(prim), .secOperand_i(sec),
        .stall_o(stall), .busy_o(busy), .stallCount_o(cnt)
    );

    // Deep-latency instance fed a constant self-dependent add, so it stalls
    // 7 of every 8 cycles and reaches counter saturation quickly.
    dependency_check #(.LATENCY(8)) dut8 (
        .clock_i(clock), .reset_i(rst8), .enable_i(1'b1), .flushBack_i(1'b0),
        .isBranch_i(1'b0), .instructionFormat_i(1'b1), .opcode_i(OP_ADD),
        .primOperand_i(5'd3), .secOperand_i(16'd0),
        .stall_o(stall8), .busy_o(busy8), .stallCount_o(cnt8)
    );

    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            compared++;
            if (stall !== e.stall || busy !== e.busy || cnt !== e.cnt) begin
                mismatched++;
                $display("FAIL %0s: stall/busy/count got %b/%b/%0d expected %b/%b/%0d",
                         e.name, stall, busy, cnt, e.stall, e.busy, e.cnt);
            end
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            compared++;
            if (stall8 !== e.stall || busy8 !== e.busy || cnt8 !== e.cnt) begin
                mismatched++;
                $display("FAIL %0s: stall/busy/count got %b/%b/%0d expected %b/%b/%0d",
                         e.name, stall8, busy8, cnt8, e.stall, e.busy, e.cnt);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic f, input logic b,
                        input logic fm, input logic [6:0] o, input logic [4:0] p,
                        input logic [15:0] s, input logic xs, input logic xb,
                        input logic [127:0] nm);
        exp_t x;
        @(posedge clock);
        #1;
        rst = r; en = e; fl = f; br = b; fmt = fm; op = o; prim = p; sec = s;
        x.stall = xs; x.busy = xb; x.cnt = model_cnt; x.name = nm;
        q.push_back(x);
        if (r) model_cnt = 16'd0;
        else if (xs && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    endtask

    task automatic ins(input logic b, input logic fm, input logic [6:0] o,
                       input logic [4:0] p, input logic [15:0] s,
                       input logic xs, input logic xb, input logic [127:0] nm);
        step(1'b0, 1'b1, 1'b0, b, fm, o, p, s, xs, xb, nm);
    endtask

    task automatic idle(input logic xb, input logic [127:0] nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 5'd0, 16'd0, 1'b0, xb, nm);
    endtask

    task automatic push8(input logic xs, input logic xb, input logic [15:0] xc,
                         input logic [127:0] nm);
        exp_t x;
        x.stall = xs; x.busy = xb; x.cnt = xc; x.name = nm;
        q8.push_back(x);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        fork
            begin
                // reset then idle
                idle(1'b0, "rst_idle0");
                idle(1'b0, "rst_idle1");
                idle(1'b0, "rst_idle2");
                // write r3, dependent rr reader on r3 next cycle
                ins(1'b0, 1'b1, OP_ADD, 5'd3, 16'd0, 1'b0, 1'b0, "s2_write");
                ins(1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b1, 1'b1, "s2_stall1");
                ins(1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b1, 1'b1, "s2_stall2");
                ins(1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b0, 1'b0, "s2_accept");
                idle(1'b1, "s2_r5_a");
                idle(1'b1, "s2_r5_b");
                idle(1'b0, "s2_drain");
                // independent instructions
                ins(1'b0, 1'b1, OP_ADD, 5'd3, 16'd0, 1'b0, 1'b0, "s3_w3");
                ins(1'b0, 1'b0, OP_ADD, 5'd4, 16'd6, 1'b0, 1'b1, "s3_w4");
                idle(1'b1, "s3_busy_a");
                idle(1'b1, "s3_busy_b");
                idle(1'b0, "s3_drain");
                // load r7 then one-register branch on r7
                ins(1'b0, 1'b1, OP_LDI, 5'd7, 16'd0, 1'b0, 1'b0, "s4_ld7");
                ins(1'b1, 1'b1, BR_EQ, 5'd7, 16'd0, 1'b1, 1'b1, "s4_br1_st1");
                ins(1'b1, 1'b1, BR_EQ, 5'd7, 16'd0, 1'b1, 1'b1, "s4_br1_st2");
                ins(1'b1, 1'b1, BR_EQ, 5'd7, 16'd0, 1'b0, 1'b0, "s4_br1_acc");
                idle(1'b0, "s4_idle");
                // op5 branch ignores its secondary even in rr format
                ins(1'b0, 1'b1, OP_LDI, 5'd7, 16'd0, 1'b0, 1'b0, "s4b_ld7");
                ins(1'b1, 1'b0, BR_Z, 5'd1, 16'd7, 1'b0, 1'b1, "s4b_br5");
                idle(1'b1, "s4b_pend");
                idle(1'b0, "s4b_drain");
                // frame op waits for busy to fall, then is not inserted
                ins(1'b0, 1'b1, OP_ADD, 5'd1, 16'd0, 1'b0, 1'b0, "s5_w1");
                ins(1'b0, 1'b1, OP_FRAME_INC, 5'd0, 16'd0, 1'b1, 1'b1, "s5_fr_st1");
                ins(1'b0, 1'b1, OP_FRAME_INC, 5'd0, 16'd0, 1'b1, 1'b1, "s5_fr_st2");
                ins(1'b0, 1'b1, OP_FRAME_INC, 5'd0, 16'd0, 1'b0, 1'b0, "s5_fr_acc");
                idle(1'b0, "s5_noins");
                // flushed hazarding reader: no stall, no insertion
                ins(1'b0, 1'b1, OP_ADD, 5'd3, 16'd0, 1'b0, 1'b0, "s6a_w3");
                step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b0, 1'b1, "s6a_flush");
                idle(1'b1, "s6a_pend");
                idle(1'b0, "s6a_noins");
                // reset in the middle of a stall
                ins(1'b0, 1'b1, OP_ADD, 5'd3, 16'd0, 1'b0, 1'b0, "s6b_w3");
                ins(1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b1, 1'b1, "s6b_stall");
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OP_ADD, 5'd5, 16'd3, 1'b0, 1'b1, "s6b_rst");
                idle(1'b0, "s6b_after");
                // r0 and r31 are tracked like any other register
                ins(1'b0, 1'b1, OP_ADD, 5'd0, 16'd0, 1'b0, 1'b0, "r0_w");
                ins(1'b0, 1'b1, OP_ST, 5'd0, 16'd0, 1'b1, 1'b1, "r0_st1");
                ins(1'b0, 1'b1, OP_ST, 5'd0, 16'd0, 1'b1, 1'b1, "r0_st2");
                ins(1'b0, 1'b1, OP_ST, 5'd0, 16'd0, 1'b0, 1'b0, "r0_acc");
                ins(1'b0, 1'b1, OP_LD, 5'd31, 16'd0, 1'b0, 1'b0, "r31_w");
                ins(1'b1, 1'b0, BR_NE, 5'd0, 16'd31, 1'b1, 1'b1, "r31_st1");
                ins(1'b1, 1'b0, BR_NE, 5'd0, 16'd31, 1'b1, 1'b1, "r31_st2");
                ins(1'b1, 1'b0, BR_NE, 5'd0, 16'd31, 1'b0, 1'b0, "r31_acc");
                // unlisted opcode reads nothing
                ins(1'b0, 1'b1, OP_ADD, 5'd3, 16'd0, 1'b0, 1'b0, "unl_w3");
                ins(1'b0, 1'b0, 7'd50, 5'd3, 16'd3, 1'b0, 1'b1, "unl_op50");
                idle(1'b1, "unl_pend");
                idle(1'b0, "unl_drain");
            end
            begin
                repeat (3) @(posedge clock);
                #1 rst8 = 1'b0;
                repeat (800) @(posedge clock);
                #1 push8(1'b0, 1'b0, 16'd700, "sat_c800");
                @(posedge clock);
                #1 push8(1'b1, 1'b1, 16'd700, "sat_c801");
                repeat (75199) @(posedge clock);
                #1 push8(1'b0, 1'b0, 16'hFFFF, "sat_c76000");
                @(posedge clock);
                #1 push8(1'b1, 1'b1, 16'hFFFF, "sat_c76001");
                @(posedge clock);
                #1 push8(1'b1, 1'b1, 16'hFFFF, "sat_c76002");
            end
        join
        repeat (2) @(posedge clock);
        if (q.size() != 0 || q8.size() != 0) begin
            mismatched++;
            $display("FAIL drain: pending expectations %0d/%0d required 0/0", q.size(), q8.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
